// File: rtl/uart_rx_if.sv
// uart_rx_if: CPU-side bus between the UART receiver and the register block.
//   re          read strobe from the CPU; consumes the holding register
//   dout        last received byte
//   full        holding register has an unread byte
//   done        one-cycle pulse when a byte is stored
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: parity mismatch (parity build only)
//   overrun     sticky: a byte was dropped because the register was full
// master = register block / CPU side, slave = receiver side.
interface uart_rx_if;
  logic       re;
  logic [7:0] dout;
  logic       full;
  logic       done;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output re,
    input  dout, full, done, frame_err, parity_err, overrun
  );

  modport slave (
    input  re,
    output dout, full, done, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN defined).
// Samples the synchronized rx line at mid-bit and stores each good byte in a
// one-entry holding register read by the CPU.
//   CLKS_PER_BIT  system clocks per serial bit (4..65535)
//   i_clk         system clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_rx          asynchronous serial input, idle high
//   bus           uart_rx_if.slave: re in; dout/full/done/frame_err/
//                 parity_err/overrun out
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after
// the data bits; when undefined parity_err is constant 0.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1000
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_rx,
  uart_rx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);

  logic        r_rx_s1, r_rx_s, r_rx_q;
  state_t      r_state, w_state_nxt;
  logic [15:0] r_count, w_count_nxt;
  logic [2:0]  r_idx,   w_idx_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_dout,  w_dout_nxt;
  logic        r_full,  w_full_nxt;
  logic        r_ovr,   w_ovr_nxt;
  logic        r_done,  w_done_nxt;
  logic        r_ferr,  w_ferr_nxt;
  logic        r_perr,  w_perr_nxt;
  logic        w_par_bad;
`ifdef UART_RX_PARITY_EN
  // Running XOR of data bits and parity bit; 1 at STOP means mismatch.
  logic        r_par,   w_par_nxt;
`endif

  // Two-flop synchronizer plus one delay for falling-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_q  <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s  <= r_rx_s1;
      r_rx_q  <= r_rx_s;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_full  <= 1'b0;
      r_ovr   <= 1'b0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_dout  <= w_dout_nxt;
      r_full  <= w_full_nxt;
      r_ovr   <= w_ovr_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
      r_perr  <= w_perr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_dout_nxt  = r_dout;
    w_full_nxt  = r_full;
    w_ovr_nxt   = r_ovr;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_perr_nxt  = 1'b0;
    w_par_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_par_bad   = r_par;
`endif

    // CPU read; a store later in this block overrides it.
    if (bus.re && r_full) begin
      w_full_nxt = 1'b0;
      w_ovr_nxt  = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        w_idx_nxt   = '0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = 1'b0;
`endif
        // Edge, not level: a line stuck low cannot start frames.
        if (r_rx_q && !r_rx_s) w_state_nxt = S_START;
      end

      S_START: begin
        if (r_count == LP_HALF) begin
          w_count_nxt = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end

      S_DATA: begin
        if (r_count == LP_FULL) begin
          w_count_nxt = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          w_par_nxt   = r_par ^ r_rx_s;
          if (r_idx == 3'd7) w_state_nxt = S_PARITY;
`else
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
`endif
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (r_count == LP_FULL) begin
          w_count_nxt = '0;
          w_par_nxt   = r_par ^ r_rx_s;
          w_state_nxt = S_STOP;
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end
`endif

      S_STOP: begin
        // Leaving at mid-stop-bit so a following start bit is not missed.
        if (r_count == LP_FULL) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_idx_nxt   = '0;
          if (!r_rx_s) begin
            w_ferr_nxt = 1'b1;
            w_perr_nxt = w_par_bad;
          end else if (w_par_bad) begin
            w_perr_nxt = 1'b1;
          end else if (!r_full || bus.re) begin
            w_dout_nxt = r_shift;
            w_full_nxt = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_ovr_nxt  = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + 16'd1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign bus.dout       = r_dout;
  assign bus.full       = r_full;
  assign bus.overrun    = r_ovr;
  assign bus.done       = r_done;
  assign bus.frame_err  = r_ferr;
  assign bus.parity_err = r_perr;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: the receive-side counterpart to the transmitter. It takes the asynchronous `rx` pin and recovers 8N1 frames by sampling at mid-bit. Each received byte goes into a one-entry holding register that the CPU bus reads. It sits between the board RX pin and the UART register block. Its bit timing matches the transmitter's `CLKS_PER_BIT`, so a loopback of `tx` to `rx` is byte-exact.

## Interface
- `CLKS_PER_BIT`, 1000, system clocks per serial bit; legal range 4..65535.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx`  in  1  asynchronous serial input; idle high.
- `re`  in  1  read strobe; consumes the holding register.
- `dout`  out  8  last received byte.
- `full`  out  1  holding register contains an unread byte.
- `done`  out  1  one-cycle pulse when a byte is stored.
- `frame_err`  out  1  one-cycle pulse: the stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).
- `overrun`  out  1  sticky: a byte was dropped because `full` was set.

## Operation
- **Synchronizer.** `rx` passes through two flops (`rx_s1`, `rx_s`). Both reset to 1. All logic below uses `rx_s` and its previous value `rx_q`.
- **States:** IDLE, START, DATA, (PARITY), STOP. The counter `count` is 16 bits; the bit index is 3 bits; there is an 8-bit shift register.
- **IDLE**
  - `count` = 0 and index = 0.
  - On `rx_q`=1 and `rx_s`=0 (falling edge), go to START.
  - A line held low never re-triggers; a rising edge is required first.
- **START**
  - `count` increments each cycle.
  - At `count` == `CLKS_PER_BIT/2 - 1` (integer division), sample `rx_s`:
    - 0: go to DATA with `count` = 0.
    - 1: glitch; return to IDLE with no output.
- **DATA**
  - At `count` == `CLKS_PER_BIT - 1`: shift right with `rx_s` into bit 7 (LSB first), increment index, set `count` = 0.
  - After the 8th bit, go to STOP, or to PARITY if configured.
- **STOP.** At `count` == `CLKS_PER_BIT - 1`, sample `rx_s` and return to IDLE:
  - 1, `full`=0 or `re`=1: `dout` <= shift register, `full` <= 1, `done` pulses.
  - 1, `full`=1 and `re`=0: byte discarded, `overrun` <= 1, no `done`.
  - 0: byte discarded, `frame_err` pulses, `full` and `dout` unchanged.
- **Read**
  - `re` while `full`: `full` <= 0 and `overrun` <= 0 next cycle. `dout` holds its value.
  - `re` while empty: no effect.
  - `re` in the same cycle as a store: the store wins (`full` stays 1, new `dout`, no overrun).
- **Unreachable state encoding** goes to IDLE.

## Timing
- **Reset values:**
  - `dout`=0x00, `full`=0, `done`=0, `frame_err`=0, `parity_err`=0, `overrun`=0.
  - State = IDLE, `count`=0.
- **Reset precedence.** Reset is sampled every edge and overrides everything, including a frame in progress. The partial frame is discarded and no pulse is emitted.
- **Edge-detect cycle.** Let E be the cycle in which IDLE sees the falling edge. E is 2–3 cycles after the pin edge, because of the synchronizer.
- **Latency.** `done` (or `frame_err`) is high exactly in cycle E + 1 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`. With parity, add `CLKS_PER_BIT`.
- **Back-to-back frames.** IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is caught. Tolerated baud mismatch is about ±4%.
- **Status outputs.** `full` and `overrun` are registered levels. `done`, `frame_err` and `parity_err` are high for exactly one cycle.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - The PARITY state follows DATA and samples one bit at `count` == `CLKS_PER_BIT - 1`. The frame format is 8E1.
  - If the XOR of the 8 data bits and the parity bit is 1: the byte is discarded at STOP and `parity_err` pulses in the `done` slot.
  - If the stop bit is also low: `frame_err` and `parity_err` both pulse, and the byte is discarded.
- **Undefined:** there is no PARITY state, the format is 8N1, and `parity_err` is tied to 0.

## Test plan
- **Single byte.** `CLKS_PER_BIT`=16, send 0xA5 8N1.
  - `done` pulses once in cycle E+153, `dout`=0xA5, `full`=1.
  - `re` → `full`=0; `dout` stays 0xA5.
- **Glitch rejection.** A 5-cycle low pulse on idle `rx` → no `done`; the FSM is back in IDLE; the next frame 0x3C is received correctly.
- **Framing error.** Send 0x55 with the stop bit low → `frame_err` pulses once, `full`=0, `dout` unchanged. Hold `rx` low 40 cycles, then send 0x12 → 0x12 received.
- **Overrun and same-cycle read.**
  - Receive 0x01, then 0x02 without `re` → `overrun`=1, `dout`=0x01.
  - `re` → `overrun`=0, `full`=0.
  - Send 0x03 with `re` asserted in the store cycle → `full`=1, `dout`=0x03, `overrun`=0.
- **Reset mid-frame.** Pulse `rst_n` low one cycle during DATA bit 4 → all outputs at reset values, no pulse. The next frame 0xFF is received correctly.
- **Parity (`UART_RX_PARITY_EN`).**
  - 0x07 with parity bit 1 → `done`, `dout`=0x07.
  - 0x07 with parity bit 0 → `parity_err` pulse, no `done`, `full` unchanged.
